// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared RV32I/RV64I base-opcode and funct constants for the
// decode stage, plus a small helper that recognises the OP_IMM shift funct3s.
// No ports; imported by decode_fields and decode_queue.
package decode_queue_pkg;

  // Major opcodes accepted by the decoder; anything else is flagged illegal.
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // funct7 values legal for register-register OP.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct7 values legal for OP_IMM shifts (logical / arithmetic).
  localparam logic [6:0] F7_SHIFT_LOGICAL = 7'b0000000;
  localparam logic [6:0] F7_SHIFT_ARITH   = 7'b0100000;

  // OP_IMM funct3 codes that are shifts rather than ALU immediates.
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLLI) || (f3 == F3_SRXI);
  endfunction

endpackage

// File: rtl/decode_queue_fields.sv
// decode_fields: purely combinational field extraction for one instruction.
// Ports:
//   instr   in  32    raw instruction
//   rd/rs1/rs2 out 5  register addresses, zero where the format has none
//   funct3  out 3     zero for LUI/AUIPC/JAL
//   funct7  out 7     only for OP and OP_IMM shifts
//   imm     out XLEN  sign-extended immediate (zero-extended shamt for shifts)
//   illegal out 1     unsupported encoding; every other output is then 0
module decode_fields
  import decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam logic IS_RV32 = (XLEN == 32);

  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm32_s;   // every immediate format fits in 32 bits sign-extended
  logic        bad_s;

  // Per-format field selection and legality check.
  always_comb begin
    rd_s     = 5'd0;
    rs1_s    = 5'd0;
    rs2_s    = 5'd0;
    funct3_s = 3'd0;
    funct7_s = 7'd0;
    imm32_s  = 32'd0;
    bad_s    = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        rd_s    = instr[11:7];
        imm32_s = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        rd_s    = instr[11:7];
        imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD: begin
        rd_s     = instr[11:7];
        rs1_s    = instr[19:15];
        funct3_s = instr[14:12];
        imm32_s  = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        rs1_s    = instr[19:15];
        rs2_s    = instr[24:20];
        funct3_s = instr[14:12];
        imm32_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      end
      OPC_STORE: begin
        rs1_s    = instr[19:15];
        rs2_s    = instr[24:20];
        funct3_s = instr[14:12];
        imm32_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OP_IMM: begin
        rd_s     = instr[11:7];
        rs1_s    = instr[19:15];
        funct3_s = instr[14:12];
        if (is_shift_f3(instr[14:12])) begin
          // RV32 keeps instr[25] in funct7 (it must be 0); RV64 uses it as shamt[5].
          if (IS_RV32) begin
            imm32_s  = {27'd0, instr[24:20]};
            funct7_s = instr[31:25];
          end else begin
            imm32_s  = {26'd0, instr[25:20]};
            funct7_s = {instr[31:26], 1'b0};
          end
          if (instr[14:12] == F3_SLLI) begin
            bad_s = (instr[31:26] != F7_SHIFT_LOGICAL[6:1]);
          end else begin
            bad_s = (instr[31:26] != F7_SHIFT_LOGICAL[6:1]) &&
                    (instr[31:26] != F7_SHIFT_ARITH[6:1]);
          end
          bad_s = bad_s || (IS_RV32 && instr[25]);
        end else begin
          imm32_s = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OP: begin
        rd_s     = instr[11:7];
        rs1_s    = instr[19:15];
        rs2_s    = instr[24:20];
        funct3_s = instr[14:12];
        funct7_s = instr[31:25];
        bad_s    = (instr[31:25] != F7_BASE) && (instr[31:25] != F7_ALT);
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  // Illegal encodings carry no decoded fields.
  assign rd      = bad_s ? 5'd0 : rd_s;
  assign rs1     = bad_s ? 5'd0 : rs1_s;
  assign rs2     = bad_s ? 5'd0 : rs2_s;
  assign funct3  = bad_s ? 3'd0 : funct3_s;
  assign funct7  = bad_s ? 7'd0 : funct7_s;
  assign imm     = bad_s ? '0 : {{(XLEN-31){imm32_s[31]}}, imm32_s[30:0]};
  assign illegal = bad_s;

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode stage with a DEPTH-entry FIFO between fetch and execute.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous queue clear (redirect), beats push/pop
//   in_valid/in_ready   fetch handshake; in_instr, in_pc accompany it
//   out_valid/out_ready consumer handshake on the head entry
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_illegal  decoded head entry, all 0 while out_valid=0
//   count               occupancy
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]      dec_rd_s;
  logic [4:0]      dec_rs1_s;
  logic [4:0]      dec_rs2_s;
  logic [2:0]      dec_funct3_s;
  logic [6:0]      dec_funct7_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_illegal_s;

  logic [XLEN-1:0] pc_mem_r     [DEPTH];
  logic [6:0]      opcode_mem_r [DEPTH];
  logic [4:0]      rd_mem_r     [DEPTH];
  logic [4:0]      rs1_mem_r    [DEPTH];
  logic [4:0]      rs2_mem_r    [DEPTH];
  logic [2:0]      funct3_mem_r [DEPTH];
  logic [6:0]      funct7_mem_r [DEPTH];
  logic [XLEN-1:0] imm_mem_r    [DEPTH];
  logic            illegal_mem_r[DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic in_ready_s;
  logic out_valid_s;
  logic push_s;
  logic pop_s;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr   (in_instr),
    .rd      (dec_rd_s),
    .rs1     (dec_rs1_s),
    .rs2     (dec_rs2_s),
    .funct3  (dec_funct3_s),
    .funct7  (dec_funct7_s),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  // in_ready depends only on local state and flush, never on out_ready.
  assign in_ready_s  = (count_r < FULL_CNT) && !flush;
  assign out_valid_s = (count_r != '0);
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  // Pointer and occupancy bookkeeping; flush clears everything next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written with the decoded fields on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]      <= '0;
        opcode_mem_r[i]  <= 7'd0;
        rd_mem_r[i]      <= 5'd0;
        rs1_mem_r[i]     <= 5'd0;
        rs2_mem_r[i]     <= 5'd0;
        funct3_mem_r[i]  <= 3'd0;
        funct7_mem_r[i]  <= 7'd0;
        imm_mem_r[i]     <= '0;
        illegal_mem_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]      <= in_pc;
      opcode_mem_r[wr_ptr_r]  <= in_instr[6:0];
      rd_mem_r[wr_ptr_r]      <= dec_rd_s;
      rs1_mem_r[wr_ptr_r]     <= dec_rs1_s;
      rs2_mem_r[wr_ptr_r]     <= dec_rs2_s;
      funct3_mem_r[wr_ptr_r]  <= dec_funct3_s;
      funct7_mem_r[wr_ptr_r]  <= dec_funct7_s;
      imm_mem_r[wr_ptr_r]     <= dec_imm_s;
      illegal_mem_r[wr_ptr_r] <= dec_illegal_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign count       = count_r;
  // Head entry is masked to zero whenever the queue is empty.
  assign out_pc      = out_valid_s ? pc_mem_r[rd_ptr_r]      : '0;
  assign out_opcode  = out_valid_s ? opcode_mem_r[rd_ptr_r]  : 7'd0;
  assign out_rd      = out_valid_s ? rd_mem_r[rd_ptr_r]      : 5'd0;
  assign out_rs1     = out_valid_s ? rs1_mem_r[rd_ptr_r]     : 5'd0;
  assign out_rs2     = out_valid_s ? rs2_mem_r[rd_ptr_r]     : 5'd0;
  assign out_funct3  = out_valid_s ? funct3_mem_r[rd_ptr_r]  : 3'd0;
  assign out_funct7  = out_valid_s ? funct7_mem_r[rd_ptr_r]  : 7'd0;
  assign out_imm     = out_valid_s ? imm_mem_r[rd_ptr_r]     : '0;
  assign out_illegal = out_valid_s ? illegal_mem_r[rd_ptr_r] : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed, table-driven bench for decode_queue.
// One XLEN=32 instance carries the vector table and the queue corner cases;
// one XLEN=64 instance checks the RV64 immediate and shift-amount handling.
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [1:0]  count;

  // XLEN=64 instance signals
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr;
  logic [63:0] b_in_pc, b_out_pc, b_out_imm;
  logic [6:0]  b_out_opcode, b_out_funct7;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [2:0]  b_out_funct3;
  logic [1:0]  b_count;

  decode_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
    .out_illegal(b_out_illegal), .count(b_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic push32(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    //           instr          pc         op      rd     rs1    rs2    f3    f7     imm            ill
    vec[0]  = '{32'hFE512E23, 32'h100, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b0}; // sw x5,-4(x2)
    vec[1]  = '{32'h4030D093, 32'h104, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h00000003, 1'b0}; // srai x1,x1,3
    vec[2]  = '{32'h4230D093, 32'h108, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1}; // shamt[5] on RV32
    vec[3]  = '{32'h0000007F, 32'h10C, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1}; // bad opcode
    vec[4]  = '{32'h002081B3, 32'h110, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 1'b0}; // add x3,x1,x2
    vec[5]  = '{32'h022081B3, 32'h114, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1}; // funct7=0000001
    vec[6]  = '{32'hFFF00293, 32'h118, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0}; // addi x5,x0,-1
    vec[7]  = '{32'hFE208CE3, 32'h11C, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 1'b0}; // beq x1,x2,-8
    vec[8]  = '{32'h008000EF, 32'h120, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0}; // jal x1,8
    vec[9]  = '{32'h41F09093, 32'h124, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1}; // slli with 0100000
    vec[10] = '{32'h800001B7, 32'h128, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000000, 1'b0}; // lui x3,0x80000
    vec[11] = '{32'hFFC08067, 32'h12C, 7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0}; // jalr x0,-4(x1)
    vec[12] = '{32'h01012303, 32'h130, 7'h03, 5'd6, 5'd2, 5'd0, 3'd2, 7'h00, 32'h00000010, 1'b0}; // lw x6,16(x2)
    vec[13] = '{32'h12345217, 32'h134, 7'h17, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0}; // auipc x4,0x12345

    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_pc = 64'd0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_imm", 64'(out_imm), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // Vector table: push, check head one cycle later, pop on the following edge.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      push32(vec[i].instr, vec[i].pc);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d.valid", i),   64'(out_valid),   64'd1);
      chk($sformatf("v%0d.pc", i),      64'(out_pc),      64'(vec[i].pc));
      chk($sformatf("v%0d.opcode", i),  64'(out_opcode),  64'(vec[i].op));
      chk($sformatf("v%0d.rd", i),      64'(out_rd),      64'(vec[i].rd));
      chk($sformatf("v%0d.rs1", i),     64'(out_rs1),     64'(vec[i].rs1));
      chk($sformatf("v%0d.rs2", i),     64'(out_rs2),     64'(vec[i].rs2));
      chk($sformatf("v%0d.funct3", i),  64'(out_funct3),  64'(vec[i].f3));
      chk($sformatf("v%0d.funct7", i),  64'(out_funct7),  64'(vec[i].f7));
      chk($sformatf("v%0d.imm", i),     64'(out_imm),     64'(vec[i].imm));
      chk($sformatf("v%0d.illegal", i), 64'(out_illegal), 64'(vec[i].ill));
    end
    @(negedge clk);
    chk("drain.count", 64'(count), 64'd0);
    chk("drain.out_pc", 64'(out_pc), 64'd0);

    // RV64: lui sign-extends to 64 bits; 0x4230D093 is srai x1,x1,35 (legal).
    b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_instr = 32'h800001B7; b_in_pc = 64'h8000_0000_0000_1000;
    @(negedge clk);
    b_in_instr = 32'h4230D093; b_in_pc = 64'h8000_0000_0000_1004;
    chk("rv64.lui.imm", b_out_imm, 64'hFFFFFFFF80000000);
    chk("rv64.lui.rd", 64'(b_out_rd), 64'd3);
    chk("rv64.lui.pc", b_out_pc, 64'h8000_0000_0000_1000);
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("rv64.srai.illegal", 64'(b_out_illegal), 64'd0);
    chk("rv64.srai.imm", b_out_imm, 64'd35);
    chk("rv64.srai.funct7", 64'(b_out_funct7), 64'h20);
    chk("rv64.srai.pc", b_out_pc, 64'h8000_0000_0000_1004);
    @(negedge clk);
    chk("rv64.drain.count", 64'(b_count), 64'd0);

    // Backpressure: fill with A,B, hold C, then release.
    out_ready = 1'b0;
    push32(32'h00000013, 32'h200);
    push32(32'h00000013, 32'h204);
    push32(32'h00000013, 32'h208);
    chk("bp.count_full", 64'(count), 64'd2);
    chk("bp.in_ready_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("bp.c_held", 64'(count), 64'd2);
    chk("bp.head_a", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.head_b", 64'(out_pc), 64'h204);
    chk("bp.count_after_pop", 64'(count), 64'd1);
    chk("bp.in_ready_reopen", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.head_c", 64'(out_pc), 64'h208);
    chk("bp.count_c", 64'(count), 64'd1);
    @(negedge clk);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush with a full queue and a valid input in the flush cycle.
    out_ready = 1'b0;
    push32(32'h00000013, 32'h300);
    push32(32'h00000013, 32'h304);
    @(negedge clk);
    in_instr = 32'h00000013; in_pc = 32'h308;
    flush = 1'b1;
    chk("fl.count_before", 64'(count), 64'd2);
    chk("fl.in_ready_in_flush", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_pc = 32'h30C;
    chk("fl.count_after", 64'(count), 64'd0);
    chk("fl.out_valid_after", 64'(out_valid), 64'd0);
    chk("fl.out_pc_after", 64'(out_pc), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl.next_push_pc", 64'(out_pc), 64'h30C);
    chk("fl.next_push_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl.no_stale", 64'(count), 64'd0);

    // Reset in the middle of traffic drops entries immediately.
    out_ready = 1'b0;
    push32(32'hFE512E23, 32'h400);
    push32(32'h800001B7, 32'h404);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr.count_before", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.count", 64'(count), 64'd0);
    chk("mr.out_valid", 64'(out_valid), 64'd0);
    chk("mr.out_imm", 64'(out_imm), 64'd0);
    chk("mr.out_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr.in_ready", 64'(in_ready), 64'd1);
    chk("mr.count_after", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage for the 3-stage RISC-V core. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and extracts opcode, register addresses, funct fields, an XLEN-wide sign-extended immediate and an illegal-instruction flag. Decoded entries are buffered in a DEPTH-entry FIFO so fetch and execute can stall independently. It sits between instruction fetch and the register-file read / execute stage.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch/jump redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_pc  out  XLEN  PC of head entry.
- out_opcode  out  7  instr[6:0].
- out_rd, out_rs1, out_rs2  out  5 each  register addresses; zero where the format has none.
- out_funct3  out  3  zero for LUI/AUIPC/JAL.
- out_funct7  out  7  meaningful for OP, and OP_IMM shifts only; zero otherwise.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  entry is an unsupported/illegal encoding.
- count  out  $clog2(DEPTH+1)  occupancy.

## Operation
- Decode is combinational on in_instr; the decoded entry is written on push (in_valid && in_ready).
- Immediates: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); J = sext({[31],[19:12],[20],[30:21],0}); U = sext({[31:12],12'b0}) to XLEN.
- OP_IMM shifts (funct3 001/101): imm = zero-extended shamt, where shamt is instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64. funct7 = {instr[31:26], instr[25] for XLEN=32 / 0 for XLEN=64}.
- Field zeroing:
  - LUI/AUIPC/JAL: rs1 = rs2 = 0.
  - JALR/LOAD/OP_IMM: rs2 = 0.
  - BRANCH/STORE: rd = 0.
  - OP: imm = 0.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
- Illegal when any of the following holds:
  - opcode is outside the legal set;
  - an OP_IMM shift has instr[31:26] other than 000000/010000 (funct3 001 additionally requires 000000);
  - an OP_IMM shift on XLEN=32 has instr[25]=1;
  - OP has funct7 other than 0000000/0100000.
- Illegal entries are enqueued normally with out_illegal=1, out_pc valid, opcode passed through, and all other fields 0.
- in_ready = (count < DEPTH) && !flush. There is no combinational path from out_ready.
- Pop on out_valid && out_ready; out_valid = (count != 0).
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Pointers wrap modulo DEPTH.
- flush: next cycle count = 0 and out_valid = 0. The entry presented in the flush cycle is not enqueued. flush takes priority over push and pop.
- When out_valid=0, all out_* data fields drive 0.

## Timing
- Reset (asynchronous assert, synchronous release effect): count=0, out_valid=0, all out_* data fields 0, pointers 0. in_ready=1 from the first cycle after release.
- Latency: an entry pushed on edge N is visible with out_valid=1 after edge N; it is presented in the next cycle, one cycle after its in_valid cycle.
- Throughput: one push and one pop per cycle.
- Full (count=DEPTH): in_ready=0; a pop that cycle reopens in_ready on the next cycle.
- Reset asserted mid-traffic discards all entries immediately.

## Structure
- Opcode and funct constants live in the shared Opcode.vh. Add the OP_IMM shift funct7 values (0000000, 0100000) there.
- One sub-module, decode_fields: purely combinational, instr → {rd, rs1, rs2, funct3, funct7, imm, illegal}, parametrised by XLEN.
- decode_queue holds the FIFO storage, pointers, count and handshake logic.

## Test plan
- Reset: drive 2 pushes with out_ready=0, then pulse rst_n low → immediately count=0, out_valid=0, out_imm=0; after release in_ready=1.
- Store, XLEN=32: in_instr=0xFE512E23 (sw x5,-4(x2)), pc=0x100 → next cycle out_opcode=0100011, rs1=2, rs2=5, rd=0, funct3=010, imm=0xFFFFFFFC, illegal=0.
- Shift, XLEN=32: 0x4030D093 (srai x1,x1,3) → imm=3, funct7=0x20, rs2=0. Then 0x4230D093 → out_illegal=1 and all fields 0. Opcode 0x0000007F → illegal=1.
- U-type, XLEN=64: 0x800001B7 (lui x3,0x80000) → out_imm=0xFFFFFFFF80000000, rd=3.
- Backpressure, DEPTH=2, out_ready=0: push A, B → in_ready=0 and count=2, C held. Raise out_ready → A, B, C emerge on consecutive cycles in order.
- Flush with count=2 and in_valid=1 → next cycle count=0 and out_valid=0, the flush-cycle instruction is absent, and the following push appears normally.
